// File: rtl/mac_job_sequencer_if.sv
// Job, operand, MulAdder and result signals shared by mac_job_sequencer and its neighbours.
// slave is the sequencer side; master is the scheduler/MulAdder side.
interface mac_job_sequencer_if #(
  parameter int LEN_W = 10
) ();
  logic             start;
  logic [LEN_W-1:0] len;
  logic [35:0]      bias;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_w;
  logic [15:0]      in_x;
  logic             mul_ce;
  logic             mul_sclr;
  logic [15:0]      mul_a;
  logic [15:0]      mul_b;
  logic [35:0]      mul_c;
  logic             mul_subtract;
  logic [35:0]      mul_p;
  logic             out_valid;
  logic             out_ready;
  logic [35:0]      out_data;
  logic             done;

  modport slave (
    input  start, len, bias, in_valid, in_w, in_x, mul_p, out_ready,
    output busy, in_ready, mul_ce, mul_sclr, mul_a, mul_b, mul_c, mul_subtract,
           out_valid, out_data, done
  );

  modport master (
    output start, len, bias, in_valid, in_w, in_x, mul_p, out_ready,
    input  busy, in_ready, mul_ce, mul_sclr, mul_a, mul_b, mul_c, mul_subtract,
           out_valid, out_data, done
  );
endinterface

// File: rtl/mac_job_sequencer.sv
// Drives one MulAdder slice through a dot-product job and returns bias + sum(w*x).
// Define MAC_SEQ_SAT_EN to saturate the 36-bit result instead of truncating it.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_CLEAR  | one-cycle SCLR of the MulAdder pipeline, accumulator cleared
// S_FEED   | accepting operand pairs, bias rides on the first beat's C
// S_DRAIN  | waiting for in-flight products to be accumulated
// S_OUTPUT | holding the result until out_ready
module mac_job_sequencer #(
  parameter int MUL_LAT = 3,
  parameter int LEN_W   = 10,
  parameter int ACC_W   = 48
) (
  input logic                  system_clk,
  input logic                  rst_n,
  mac_job_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FEED   = 3'd2,
    S_DRAIN  = 3'd3,
    S_OUTPUT = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [LEN_W-1:0]   r_len, r_cnt, w_cnt_inc;
  logic [35:0]        r_bias;
  logic [MUL_LAT-1:0] r_tag;
  logic [MUL_LAT:0]   w_tag_sh;
  logic [ACC_W-1:0]   r_acc;
  logic               r_mul_ce, r_mul_sclr, r_out_valid, r_done;
  logic [15:0]        r_mul_a, r_mul_b;
  logic [35:0]        r_mul_c, r_out_data;
  logic               w_mul_ce, w_mul_sclr, w_tag_in, w_in_hs, w_out_hs;
  logic [15:0]        w_mul_a, w_mul_b;
  logic [35:0]        w_mul_c, w_res;

  assign w_in_hs   = bus.in_valid && (r_state == S_FEED);
  assign w_out_hs  = r_out_valid && bus.out_ready;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_tag_sh  = {r_tag, w_tag_in};

  always_comb begin
    w_state_nxt = r_state;
    w_mul_ce    = 1'b0;
    w_mul_sclr  = 1'b0;
    w_mul_a     = '0;
    w_mul_b     = '0;
    w_mul_c     = '0;
    w_tag_in    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = (bus.len != '0) ? S_CLEAR : S_OUTPUT;
      end
      S_CLEAR: begin
        w_mul_sclr  = 1'b1;
        w_mul_ce    = 1'b1;
        w_state_nxt = S_FEED;
      end
      S_FEED: begin
        w_mul_ce = 1'b1;
        if (w_in_hs) begin
          w_mul_a  = bus.in_w;
          w_mul_b  = bus.in_x;
          w_mul_c  = (r_cnt == '0) ? r_bias : '0;
          w_tag_in = 1'b1;
          if (w_cnt_inc == r_len) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_mul_ce = 1'b1;
        if (r_tag == '0) w_state_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (w_out_hs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
`ifdef MAC_SEQ_SAT_EN
    if ((&r_acc[ACC_W-1:35]) || (~|r_acc[ACC_W-1:35])) w_res = r_acc[35:0];
    else if (r_acc[ACC_W-1])                            w_res = {1'b1, {35{1'b0}}};
    else                                                w_res = {1'b0, {35{1'b1}}};
`else
    w_res = r_acc[35:0];
`endif
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_bias      <= '0;
      r_tag       <= '0;
      r_acc       <= '0;
      r_mul_ce    <= 1'b0;
      r_mul_sclr  <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_c     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mul_ce   <= w_mul_ce;
      r_mul_sclr <= w_mul_sclr;
      r_mul_a    <= w_mul_a;
      r_mul_b    <= w_mul_b;
      r_mul_c    <= w_mul_c;
      r_done     <= 1'b0;
      if (r_state != S_IDLE) r_tag <= w_tag_sh[MUL_LAT-1:0];
      // The top tag bit marks the cycle whose mul_p belongs to an accepted pair.
      if (r_tag[MUL_LAT-1]) r_acc <= r_acc + {{(ACC_W-36){bus.mul_p[35]}}, bus.mul_p};
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_len  <= bus.len;
            r_bias <= bus.bias;
            if (bus.len == '0) begin
              r_acc       <= {{(ACC_W-36){bus.bias[35]}}, bus.bias};
              r_out_data  <= bus.bias;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          r_acc <= '0;
          r_cnt <= '0;
        end
        S_FEED: begin
          if (w_in_hs) r_cnt <= w_cnt_inc;
        end
        S_DRAIN: begin
          if (r_tag == '0) begin
            r_out_data  <= w_res;
            r_out_valid <= 1'b1;
          end
        end
        S_OUTPUT: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (r_state != S_IDLE);
  assign bus.in_ready     = (r_state == S_FEED);
  assign bus.mul_ce       = r_mul_ce;
  assign bus.mul_sclr     = r_mul_sclr;
  assign bus.mul_a        = r_mul_a;
  assign bus.mul_b        = r_mul_b;
  assign bus.mul_c        = r_mul_c;
  assign bus.mul_subtract = 1'b0;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_data;
  assign bus.done         = r_done;

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Table-driven bench for mac_job_sequencer with a behavioural 3-cycle MulAdder model.
// Build with MAC_SEQ_SAT_EN defined to exercise the saturating result path.
module tb_mac_job_sequencer;
  localparam int MUL_LAT = 3;
  localparam int LEN_W   = 10;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  mac_job_sequencer_if #(.LEN_W(LEN_W)) bus ();

  mac_job_sequencer #(.MUL_LAT(MUL_LAT), .LEN_W(LEN_W), .ACC_W(48)) dut (
    .system_clk (clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // MulAdder model: registered inputs in the DUT plus MUL_LAT-1 internal stages.
  logic signed [35:0] m_pipe [MUL_LAT-1];
  logic signed [35:0] m_ea, m_eb;
  assign m_ea = {{20{bus.mul_a[15]}}, bus.mul_a};
  assign m_eb = {{20{bus.mul_b[15]}}, bus.mul_b};
  always @(posedge clk) begin
    if (bus.mul_ce) begin
      if (bus.mul_sclr) begin
        for (int i = 0; i < MUL_LAT - 1; i++) m_pipe[i] <= '0;
      end else begin
        m_pipe[0] <= m_ea * m_eb + $signed(bus.mul_c);
        for (int i = 1; i < MUL_LAT - 1; i++) m_pipe[i] <= m_pipe[i-1];
      end
    end
  end
  assign bus.mul_p = m_pipe[MUL_LAT-2];

  int         mon_done = 0, mon_sclr = 0, mon_ce = 0, mon_viol = 0;
  logic       prev_valid = 1'b0;
  logic [35:0] prev_data = '0;
  always @(negedge clk) begin
    if (bus.done) mon_done++;
    if (bus.mul_sclr) mon_sclr++;
    if (bus.mul_ce) mon_ce++;
    if (bus.in_ready && (!bus.busy || bus.out_valid)) mon_viol++;
    if (bus.out_valid && prev_valid && bus.out_data != prev_data) mon_viol++;
    if (bus.mul_subtract) mon_viol++;
    prev_valid = bus.out_valid;
    prev_data  = bus.out_data;
  end

  typedef struct {
    int                     len;
    longint                 bias;
    logic [3:0][15:0]       w;
    logic [3:0][15:0]       x;
    int                     gap;
    int                     hold;
    longint                 exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input vec_t v, input int count);
    for (int i = 0; i < count; i++) begin
      bit ok;
      ok = 0;
      bus.in_valid = 1'b1;
      bus.in_w     = v.w[i % 4];
      bus.in_x     = v.x[i % 4];
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (bus.in_ready) begin
          ok = 1;
          break;
        end
      end
      chk("in_ready_timeout", longint'(ok), 1);
      tick();
      bus.in_valid = 1'b0;
      bus.in_w     = '0;
      bus.in_x     = '0;
      repeat (v.gap) tick();
    end
  endtask

  task automatic start_job(input vec_t v);
    tick();
    bus.start = 1'b1;
    bus.len   = LEN_W'(v.len);
    bus.bias  = 36'(v.bias);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_job(input int idx);
    vec_t v;
    int d0, s0, c0, waited;
    v  = vecs[idx];
    d0 = mon_done;
    s0 = mon_sclr;
    c0 = mon_ce;
    bus.out_ready = (v.hold == 0);
    start_job(v);
    feed(v, v.len);
    waited = 0;
    for (int k = 0; k < 300 && !bus.out_valid; k++) begin
      @(negedge clk);
      waited++;
    end
    chk($sformatf("job%0d_out_valid", idx), longint'(bus.out_valid), 1);
    chk($sformatf("job%0d_out_data", idx), longint'($signed(bus.out_data)), v.exp);
    if (v.len == 0) chk($sformatf("job%0d_fast_result", idx), longint'(waited <= 1), 1);
    if (v.hold > 0) begin
      for (int h = 0; h < v.hold; h++) begin
        tick();
        bus.start = (h == 0);
        bus.len   = LEN_W'(1);
        bus.bias  = 36'(5);
      end
      bus.start = 1'b0;
      @(negedge clk);
      chk($sformatf("job%0d_held_valid", idx), longint'(bus.out_valid), 1);
      chk($sformatf("job%0d_held_data", idx), longint'($signed(bus.out_data)), v.exp);
      chk($sformatf("job%0d_no_early_done", idx), longint'(mon_done - d0), 0);
      #1 bus.out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("job%0d_done", idx), longint'(bus.done), 1);
    chk($sformatf("job%0d_valid_fell", idx), longint'(bus.out_valid), 0);
    tick();
    @(negedge clk);
    chk($sformatf("job%0d_done_once", idx), longint'(mon_done - d0), 1);
    chk($sformatf("job%0d_idle_after", idx), longint'(bus.busy), 0);
    chk($sformatf("job%0d_sclr_count", idx), longint'(mon_sclr - s0), (v.len == 0) ? 0 : 1);
    if (v.len == 0) chk($sformatf("job%0d_ce_count", idx), longint'(mon_ce - c0), 0);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vr;
    int    d0;
    longint sat_exp;
`ifdef MAC_SEQ_SAT_EN
    sat_exp = 64'sd34359738367;
`else
    sat_exp = -64'sd25769803776;
`endif
    vecs[0] = '{1, 0, {16'sd0, 16'sd0, 16'sd0, -16'sd10}, {16'sd0, 16'sd0, 16'sd0, -16'sd5}, 0, 0, 50};
    vecs[1] = '{3, 100, {16'sd0, -16'sd1, 16'sd4, 16'sd2}, {16'sd0, 16'sd7, 16'sd5, 16'sd3}, 2, 0, 119};
    vecs[2] = '{0, -20, '0, '0, 0, 0, -20};
    vecs[3] = '{2, 0, {16'sd0, 16'sd0, -16'sd3, 16'sd100}, {16'sd0, 16'sd0, 16'sd4, 16'sd100}, 0, 5, 9988};
    vecs[4] = '{40, 0, {4{16'h8000}}, {4{16'h8000}}, 0, 0, sat_exp};
    vecs[5] = '{1, 1, {16'sd0, 16'sd0, 16'sd0, 16'sd7}, {16'sd0, 16'sd0, 16'sd0, 16'sd6}, 0, 0, 43};

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.bias      = '0;
    bus.in_valid  = 1'b0;
    bus.in_w      = '0;
    bus.in_x      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", longint'({bus.busy, bus.in_ready, bus.mul_ce, bus.mul_sclr, bus.out_valid,
        bus.done, |bus.mul_a, |bus.mul_b, |bus.mul_c, |bus.out_data}), 0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_job(i);

    // Abort a 5-pair job after two accepted pairs.
    vr      = vecs[0];
    vr.len  = 5;
    vr.w    = {16'sd9, 16'sd9, 16'sd9, 16'sd9};
    vr.x    = {16'sd3, 16'sd3, 16'sd3, 16'sd3};
    d0      = mon_done;
    start_job(vr);
    feed(vr, 2);
    @(negedge clk);
    chk("mid_feed_busy", longint'(bus.in_ready), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", longint'({bus.busy, bus.in_ready, bus.mul_ce, bus.mul_sclr,
        bus.out_valid, bus.done, |bus.mul_a, |bus.mul_b, |bus.mul_c, |bus.out_data}), 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("abort_no_done", longint'(mon_done - d0), 0);
    chk("abort_idle", longint'(bus.busy), 0);

    run_job(5);
    chk("monitor_violations", longint'(mon_viol), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_job_sequencer.md
Name: mac_job_sequencer

Overview:
- Sequences one shared MulAdder DSP slice (A 16b, B 16b, C 36b, P 36b; product plus C; pipelined) through a dot-product job: len weight/activation pairs plus a bias.
- Drives the slice's CE, SCLR, A, B, C and SUBTRACT, and tags in-flight beats.
- Accumulates the returned P values into a 48-bit accumulator and presents the 36-bit neuron result on a valid/ready port.
- Sits between the layer scheduler and one MulAdder instance.

Parameters:
MUL_LAT, 3, MulAdder input-to-P latency in cycles with CE held high; must be at least 1
LEN_W, 10, width of the job length field; maximum length is 2^LEN_W-1
ACC_W, 48, internal accumulator width; must be at least 37

Ports:
system_clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  job request; sampled only in IDLE
len  in  LEN_W  number of pairs, unsigned
bias  in  36  signed bias
busy  out  1  high in every state except IDLE
in_valid  in  1  operand pair valid
in_ready  out  1  operand pair accepted
in_w  in  16  signed weight
in_x  in  16  signed activation
mul_ce  out  1  MulAdder CE
mul_sclr  out  1  MulAdder SCLR
mul_a  out  16  MulAdder A
mul_b  out  16  MulAdder B
mul_c  out  36  MulAdder C
mul_subtract  out  1  MulAdder SUBTRACT; tied 0
mul_p  in  36  MulAdder P, signed
out_valid  out  1  result valid
out_ready  in  1  result consumer ready
out_data  out  36  signed result
done  out  1  one-cycle pulse on the result handshake

Behaviour:
- Reset: every output is 0, state is IDLE, counters, tag pipe and accumulator are cleared. Reset asserted mid-job abandons the job with no result and no done pulse.
- Registered outputs: mul_a, mul_b, mul_c, mul_ce, mul_sclr, out_valid, out_data and done.
- in_ready is combinational: 1 exactly when state is FEED.
- IDLE:
  - start=1 with len!=0: latch len and bias, go to CLEAR.
  - start=1 with len==0: load acc=sign-extended bias, go to OUTPUT; the MulAdder is not touched.
  - start while busy is ignored.
- CLEAR (1 cycle): mul_sclr=1, mul_ce=1, acc=0, issue count=0. Go to FEED.
- FEED:
  - mul_ce=1 every cycle.
  - On handshake (in_valid and in_ready): mul_a=in_w, mul_b=in_x, push tag 1.
  - mul_c=bias on the first accepted beat, 0 on all later beats.
  - With no handshake: mul_a=mul_b=mul_c=0 and push tag 0 (bubble).
  - The handshake that makes the issue count equal len moves the FSM to DRAIN.
- Tag pipe:
  - MUL_LAT-deep shift register, shifted every cycle while busy.
  - Cycles whose registered MulAdder inputs carry no accepted pair (CLEAR, bubbles, DRAIN) carry tag 0.
  - When the tag output is 1, acc += sign-extended mul_p.
  - Timing: a handshake at cycle t is accumulated at the edge ending cycle t+MUL_LAT.
- DRAIN: mul_ce=1, inputs 0. Stay until the tag pipe is all zero and the last accumulate has been taken, then go to OUTPUT.
- OUTPUT:
  - mul_ce=0. out_valid=1 and out_data stay stable until out_ready.
  - On the handshake: out_valid falls, done=1 for one cycle, go to IDLE.
  - A start in the same cycle is not sampled; the next job starts the following cycle at the earliest.
- Arithmetic: two's complement throughout. acc wraps at ACC_W. The conversion from ACC_W to 36 bits is set by SAT_EN.
- Latency: with len=N, no stalls and out_ready=1, done is asserted N+MUL_LAT+3 cycles after start, ±1 for the DRAIN exit check.

Optional Feature:
- Macro: MAC_SEQ_SAT_EN.
- Defined: out_data saturates acc to the signed 36-bit range, [-2^35, 2^35-1].
- Undefined: out_data is acc[35:0], plain truncation.

Test Plan:
- start, len=1, bias=0, pair (-10,-5), out_ready=1 -> out_data=50; mul_sclr pulses once; done pulses once.
- len=3, bias=100, pairs (2,3),(4,5),(-1,7), in_valid gapped by 2 idle cycles between pairs -> out_data=119; bubbles do not corrupt acc; in_ready high only in FEED.
- len=0, bias=-20 -> out_data=-20 within 2 cycles of start; mul_ce never asserted.
- len=2, pairs (100,100),(-3,4), out_ready held 0 for 5 cycles -> out_data=9988 held stable; done pulses on the cycle out_ready rises; start pulsed during OUTPUT is ignored.
- len=40, all pairs (-32768,-32768), bias=0 -> with MAC_SEQ_SAT_EN, out_data=34359738367; without it, out_data=-25769803776.
- rst_n pulled low mid-FEED after 2 of 5 pairs, then a fresh job len=1, pair (7,6), bias=1 -> all outputs 0 during reset, no stale done; second job gives 43.
